// File: rtl/result_checker.sv
// Result checker: streams the result matrix out of CPU data memory and compares
// it word-for-word against an expected-result ROM. Reports pass/fail, a
// saturating mismatch count and the index of the first mismatching word.
module result_checker #(
    parameter int unsigned M      = 100,
    parameter int unsigned N      = 50,
    parameter int unsigned N2     = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [WIDTH-1:0]  exp_data,
    output logic              busy,
    output logic              check_done,
    output logic              pass,
    output logic [15:0]       mismatch_count,
    output logic [15:0]       first_mismatch_idx,
    output logic [9:0]        LEDR
);

    localparam int unsigned T        = M * N2;
    localparam int unsigned RES_BASE = M * N + N * N2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic              launch;
    logic              last_issue;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_dly_q;   // word whose read data is arriving this cycle
    logic              issued_q;    // at least one read issued since launch
    logic              compare_en;
    logic              mismatch;
    logic [15:0]       count_q, count_nxt;
    logic [15:0]       first_q;
    logic              pass_q;
    logic              done_q;

    // Start edge is only honoured when no check is in flight.
    assign launch     = start & ~start_q & ((state_q == StIdle) || (state_q == StDone));
    assign last_issue = (idx_q == ADDR_W'(T - 1));
    assign compare_en = ((state_q == StRun) && issued_q) || (state_q == StDrain);
    assign mismatch   = compare_en && (rd_data != exp_data);

    // Saturating increment of the mismatch counter.
    always_comb begin
        count_nxt = count_q;
        if (mismatch && (count_q != 16'hFFFF)) begin
            count_nxt = count_q + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (launch) state_d = StRun;
            StRun:   if (last_issue) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  if (launch) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and the index register.
    always_comb begin
        busy     = (state_q == StRun) || (state_q == StDrain);
        rd_addr  = '0;
        exp_addr = '0;
        if (state_q == StRun) begin
            rd_addr  = ADDR_W'(RES_BASE) + idx_q;
            exp_addr = idx_q;
        end
        check_done         = done_q;
        pass               = pass_q;
        mismatch_count     = count_q;
        first_mismatch_idx = first_q;
        LEDR               = {count_q[6:0], busy, done_q, pass_q};
    end

    // Datapath: index, delayed index, comparison results.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            start_q   <= 1'b0;
            idx_q     <= '0;
            idx_dly_q <= '0;
            issued_q  <= 1'b0;
            count_q   <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q <= start;
            if (launch) begin
                idx_q    <= '0;
                issued_q <= 1'b0;
                count_q  <= '0;
                first_q  <= '0;
                pass_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                if (state_q == StRun) begin
                    idx_q     <= idx_q + 1'b1;
                    idx_dly_q <= idx_q;
                    issued_q  <= 1'b1;
                end
                if (compare_en) begin
                    count_q <= count_nxt;
                    if (mismatch && (count_q == 16'd0)) begin
                        first_q <= 16'(idx_dly_q);
                    end
                end
                // Pass includes the final comparison made on the drain edge.
                if (state_q == StDrain) begin
                    done_q <= 1'b1;
                    pass_q <= (count_nxt == 16'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker with M=N=N2=2 (T=4, RES_BASE=8).
module tb_result_checker;

    localparam int T        = 4;
    localparam int RES_BASE = 8;

    logic        CLOCK_50 = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] rd_addr, exp_addr;
    logic [31:0] rd_data, exp_data;
    logic        busy, check_done, pass;
    logic [15:0] mismatch_count, first_mismatch_idx;
    logic [9:0]  LEDR;

    logic [31:0] dmem [0:15];
    logic [31:0] rom  [0:3];

    int n_vec = 0;
    int n_err = 0;

    int exp_cnt;
    int exp_first;

    result_checker #(.M(2), .N(2), .N2(2), .WIDTH(32), .ADDR_W(16)) dut (
        .CLOCK_50          (CLOCK_50),
        .rst               (rst),
        .start             (start),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .exp_addr          (exp_addr),
        .exp_data          (exp_data),
        .busy              (busy),
        .check_done        (check_done),
        .pass              (pass),
        .mismatch_count    (mismatch_count),
        .first_mismatch_idx(first_mismatch_idx),
        .LEDR              (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge CLOCK_50) begin
        rd_data  <= dmem[rd_addr[3:0]];
        exp_data <= rom[exp_addr[1:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: count differing words of the result region, note the first one.
    task automatic model();
        exp_cnt   = 0;
        exp_first = 0;
        for (int i = 0; i < T; i++) begin
            if (dmem[RES_BASE + i] != rom[i]) begin
                if (exp_cnt == 0) exp_first = i;
                exp_cnt++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".rd_addr"}, 32'(rd_addr), 0);
        check_eq({tag, ".exp_addr"}, 32'(exp_addr), 0);
        check_eq({tag, ".busy"}, 32'(busy), 0);
        check_eq({tag, ".done"}, 32'(check_done), 0);
        check_eq({tag, ".pass"}, 32'(pass), 0);
        check_eq({tag, ".count"}, 32'(mismatch_count), 0);
        check_eq({tag, ".first"}, 32'(first_mismatch_idx), 0);
        check_eq({tag, ".ledr"}, 32'(LEDR), 0);
    endtask

    // Called at the first negedge after the start edge was accepted.
    task automatic run_body(input string tag, input bit glitch);
        logic [9:0] want_led;
        model();
        for (int i = 0; i < T; i++) begin
            check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'(RES_BASE + i));
            check_eq({tag, ".exp_addr"}, 32'(exp_addr), 32'(i));
            check_eq({tag, ".busy_run"}, 32'(busy), 1);
            check_eq({tag, ".done_run"}, 32'(check_done), 0);
            if (glitch && i == 1) start = 1'b1;
            if (glitch && i == 2) start = 1'b0;
            @(negedge CLOCK_50);
        end
        check_eq({tag, ".busy_drain"}, 32'(busy), 1);
        check_eq({tag, ".done_drain"}, 32'(check_done), 0);
        check_eq({tag, ".rd_addr_drain"}, 32'(rd_addr), 0);
        @(negedge CLOCK_50);
        want_led = {7'(exp_cnt), 1'b0, 1'b1, 1'(exp_cnt == 0)};
        check_eq({tag, ".done"}, 32'(check_done), 1);
        check_eq({tag, ".busy_done"}, 32'(busy), 0);
        check_eq({tag, ".pass"}, 32'(pass), 32'(exp_cnt == 0));
        check_eq({tag, ".count"}, 32'(mismatch_count), 32'(exp_cnt));
        check_eq({tag, ".first"}, 32'(first_mismatch_idx), 32'(exp_first));
        check_eq({tag, ".ledr"}, 32'(LEDR), 32'(want_led));
    endtask

    task automatic run_check(input string tag, input bit glitch);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        run_body(tag, glitch);
    endtask

    task automatic load_base();
        for (int i = 0; i < 16; i++) dmem[i] = 32'hDEAD_0000 + 32'(i);
        dmem[8]  = 32'd5;
        dmem[9]  = -32'sd3;
        dmem[10] = 32'd7;
        dmem[11] = 32'd0;
        for (int i = 0; i < T; i++) rom[i] = dmem[RES_BASE + i];
    endtask

    initial begin
        load_base();
        repeat (2) @(negedge CLOCK_50);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge CLOCK_50);
        check_all_zero("idle");

        // All words match.
        run_check("match", 1'b0);

        // One differing word at index 2.
        rom[2] = 32'd6;
        run_check("one_diff", 1'b0);

        // Every word differs, including a sign-only difference.
        rom[0] = 32'd4;
        rom[1] = 32'd3;
        rom[2] = 32'd6;
        rom[3] = 32'd1;
        run_check("all_diff", 1'b0);

        // Reset mid-run while idx == 1 leaves nothing behind.
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        rst = 1'b1;
        @(negedge CLOCK_50);
        check_all_zero("abort");
        rst = 1'b0;
        @(negedge CLOCK_50);
        run_check("after_abort", 1'b0);

        // Start edge during RUN is ignored; then a matching rerun clears results.
        load_base();
        rom[1] = 32'd99;
        run_check("glitch", 1'b1);
        load_base();
        run_check("rerun", 1'b0);

        // Start held high across reset release launches exactly once.
        rom[3] = 32'h8000_0000;
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        rst = 1'b0;
        @(negedge CLOCK_50);
        run_body("held", 1'b0);
        repeat (3) @(negedge CLOCK_50);
        check_eq("held.stay_done", 32'(check_done), 1);
        check_eq("held.stay_idle", 32'(busy), 0);
        check_eq("held.stay_count", 32'(mismatch_count), 1);
        start = 1'b0;
        @(negedge CLOCK_50);

        // Randomised result regions against the reference model.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < T; i++) begin
                logic [31:0] w;
                w = $urandom;
                dmem[RES_BASE + i] = w;
                if ($urandom_range(0, 1) == 1) w = w ^ (32'd1 << $urandom_range(0, 31));
                rom[i] = w;
            end
            run_check("random", 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
